// File: rtl/priority_encoder_pkg.sv
// ---------------------------------------------------------------------------
// priority_encoder_pkg
// Purpose : shared configuration for the two-sided priority encoder slice.
//           Holds the default word width so the top level and the one-hot
//           scanner agree on it without repeating the literal.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package priority_encoder_pkg;

   // Default width of the encoded word and of both one-hot result masks
   localparam int DEFAULT_WIDTH = 5;

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_onehot_msb.sv
// ---------------------------------------------------------------------------
// onehot_msb
// Purpose : purely combinational highest-set-bit isolator. Returns a mask
//           with only the most significant set bit of data kept, or all
//           zeros when data is zero.
// Ports   :
//   data    in   WIDTH : word to scan
//   onehot  out  WIDTH : one-hot mask of the highest set bit (0 if none)
// ---------------------------------------------------------------------------
module onehot_msb
   import priority_encoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] onehot
);

   // Scan from the MSB down; the first set bit found claims the output and
   // blocks every lower bit from also being reported.
   always_comb begin
      logic found;
      found  = 1'b0;
      onehot = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && data[i]) begin
            onehot[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule : onehot_msb

// File: rtl/priority_encoder.sv
// ---------------------------------------------------------------------------
// priority_encoder
// Purpose : registered two-sided priority encoder. For every qualified input
//           word it produces a one-hot mask of the highest set bit (left)
//           and of the lowest set bit (right), one clock later.
// Ports   :
//   clk_i         in   1     : clock, all state updates on the rising edge
//   srst_i        in   1     : asynchronous active-low reset
//   data_val_i    in   1     : qualifier for data_i
//   data_i        in   WIDTH : word to encode
//   data_left_o   out  WIDTH : one-hot mask of the highest set bit
//   data_right_o  out  WIDTH : one-hot mask of the lowest set bit
//   data_val_o    out  1     : qualifier for both masks
// ---------------------------------------------------------------------------
module priority_encoder
   import priority_encoder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             data_val_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_left_o,
   output logic [WIDTH-1:0] data_right_o,
   output logic             data_val_o
);

   logic [WIDTH-1:0] left_mask;
   logic [WIDTH-1:0] data_rev;
   logic [WIDTH-1:0] right_rev;
   logic [WIDTH-1:0] right_mask;

   // The lowest set bit of a word is the highest set bit of its mirror
   // image, so the same scanner serves both sides: mirror the input, scan,
   // then mirror the result back into place.
   for (genvar g = 0; g < WIDTH; g++) begin : g_mirror
      assign data_rev[g]   = data_i[WIDTH-1-g];
      assign right_mask[g] = right_rev[WIDTH-1-g];
   end

   onehot_msb #(
      .WIDTH (WIDTH)
   ) u_left_scan (
      .data   (data_i),
      .onehot (left_mask)
   );

   onehot_msb #(
      .WIDTH (WIDTH)
   ) u_right_scan (
      .data   (data_rev),
      .onehot (right_rev)
   );

   // Output register stage. A qualified word updates both masks and raises
   // the valid flag; an unqualified cycle only drops the valid flag so the
   // last result stays visible for whoever still needs it.
   always_ff @(posedge clk_i or negedge srst_i) begin
      if (!srst_i) begin
         data_left_o  <= '0;
         data_right_o <= '0;
         data_val_o   <= 1'b0;
      end else if (data_val_i) begin
         data_left_o  <= left_mask;
         data_right_o <= right_mask;
         data_val_o   <= 1'b1;
      end else begin
         data_val_o   <= 1'b0;
      end
   end

endmodule : priority_encoder

// File: tb/tb_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder
// Purpose : directed self-checking bench for priority_encoder at WIDTH=5.
// Ports   : none (top-level bench)
// ---------------------------------------------------------------------------
module tb_priority_encoder;

   localparam int W = 5;

   logic         clk_i;
   logic         srst_i;
   logic         data_val_i;
   logic [W-1:0] data_i;
   logic [W-1:0] data_left_o;
   logic [W-1:0] data_right_o;
   logic         data_val_o;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_left;
   logic [W-1:0] exp_right;
   logic         exp_val;

   priority_encoder #(
      .WIDTH (W)
   ) dut (
      .clk_i        (clk_i),
      .srst_i       (srst_i),
      .data_val_i   (data_val_i),
      .data_i       (data_i),
      .data_left_o  (data_left_o),
      .data_right_o (data_right_o),
      .data_val_o   (data_val_o)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference: highest set bit by scanning up from the LSB, last hit wins
   function automatic logic [W-1:0] model_left(input logic [W-1:0] d);
      logic [W-1:0] m;
      m = '0;
      for (int i = 0; i < W; i++)
         if (d[i]) m = W'(1) << i;
      return m;
   endfunction

   // Reference: lowest set bit by two's-complement isolation
   function automatic logic [W-1:0] model_right(input logic [W-1:0] d);
      logic [W-1:0] neg;
      neg = ~d + W'(1);
      return d & neg;
   endfunction

   // Drive one word between edges, let the next rising edge capture it and
   // return 1 time unit later so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic val, input logic [W-1:0] d);
      @(negedge clk_i);
      data_val_i = val;
      data_i     = d;
      @(posedge clk_i);
      #1;
   endtask

   // Compare all three outputs against the expected values
   task automatic checkOutput(input string tag, input logic [W-1:0] el,
                              input logic [W-1:0] er, input logic ev);
      checks++;
      assert (data_left_o === el) else begin
         failures++;
         $error("[TB] FAIL %s left observed=%b expected=%b", tag, data_left_o, el);
      end
      checks++;
      assert (data_right_o === er) else begin
         failures++;
         $error("[TB] FAIL %s right observed=%b expected=%b", tag, data_right_o, er);
      end
      checks++;
      assert (data_val_o === ev) else begin
         failures++;
         $error("[TB] FAIL %s val observed=%b expected=%b", tag, data_val_o, ev);
      end
   endtask

   // Back-to-back stream table: valid toggles every cycle
   logic [W-1:0] stream_data [10];
   initial begin
      stream_data[0] = 5'b01100; stream_data[1] = 5'b10001;
      stream_data[2] = 5'b00010; stream_data[3] = 5'b11000;
      stream_data[4] = 5'b10110; stream_data[5] = 5'b00111;
      stream_data[6] = 5'b01000; stream_data[7] = 5'b00000;
      stream_data[8] = 5'b11011; stream_data[9] = 5'b10100;
   end

   initial begin
      srst_i     = 1'b1;
      data_val_i = 1'b1;
      data_i     = 5'b10101;
      #1 srst_i  = 1'b0;
      #1;
      checkOutput("reset_async", 5'b00000, 5'b00000, 1'b0);

      // Held in reset with a valid word present: nothing may be captured
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'b10101);
         checkOutput("reset_hold", 5'b00000, 5'b00000, 1'b0);
      end

      @(negedge clk_i);
      srst_i = 1'b1;

      // Extremes
      applyStimulus(1'b1, 5'b11111);
      checkOutput("all_ones", 5'b10000, 5'b00001, 1'b1);
      applyStimulus(1'b1, 5'b00000);
      checkOutput("all_zero", 5'b00000, 5'b00000, 1'b1);

      // Mixed words
      applyStimulus(1'b1, 5'b00110);
      checkOutput("w00110", 5'b00100, 5'b00010, 1'b1);
      applyStimulus(1'b1, 5'b00101);
      checkOutput("w00101", 5'b00100, 5'b00001, 1'b1);
      applyStimulus(1'b1, 5'b00100);
      checkOutput("w00100", 5'b00100, 5'b00100, 1'b1);
      applyStimulus(1'b1, 5'b10000);
      checkOutput("w10000", 5'b10000, 5'b10000, 1'b1);
      applyStimulus(1'b1, 5'b00001);
      checkOutput("w00001", 5'b00001, 5'b00001, 1'b1);

      // Hold on invalid
      applyStimulus(1'b1, 5'b00101);
      checkOutput("hold_load", 5'b00100, 5'b00001, 1'b1);
      applyStimulus(1'b0, 5'b01010);
      checkOutput("hold_idle", 5'b00100, 5'b00001, 1'b0);
      applyStimulus(1'b1, 5'b00001);
      checkOutput("hold_resume", 5'b00001, 5'b00001, 1'b1);

      // Mid-stream reset pulse clears outputs without a clock edge
      applyStimulus(1'b1, 5'b11111);
      checkOutput("pre_pulse", 5'b10000, 5'b00001, 1'b1);
      #2 srst_i = 1'b0;
      #1;
      checkOutput("mid_reset", 5'b00000, 5'b00000, 1'b0);
      srst_i = 1'b1;
      applyStimulus(1'b0, 5'b11111);
      checkOutput("post_pulse_idle", 5'b00000, 5'b00000, 1'b0);

      // Back-to-back stream against the model, valid toggling per cycle
      exp_left  = 5'b00000;
      exp_right = 5'b00000;
      for (int i = 0; i < 10; i++) begin
         logic v;
         v = (i % 2 == 0);
         applyStimulus(v, stream_data[i]);
         if (v) begin
            exp_left  = model_left(stream_data[i]);
            exp_right = model_right(stream_data[i]);
         end
         exp_val = v;
         checkOutput($sformatf("stream%0d", i), exp_left, exp_right, exp_val);
      end

      // Exhaustive sweep with structural sanity on the results
      for (int i = 0; i < 32; i++) begin
         logic [W-1:0] d;
         d = W'(i);
         applyStimulus(1'b1, d);
         checkOutput($sformatf("exh%0d", i), model_left(d), model_right(d), 1'b1);
         if (d != '0) begin
            checks++;
            assert ($onehot(data_left_o) && $onehot(data_right_o)) else begin
               failures++;
               $error("[TB] FAIL exh_onehot%0d observed=%b/%b expected=one-hot", i,
                      data_left_o, data_right_o);
            end
            checks++;
            assert (data_left_o >= data_right_o) else begin
               failures++;
               $error("[TB] FAIL exh_order%0d observed=%b<%b expected=left>=right", i,
                      data_left_o, data_right_o);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_priority_encoder
